ucie_sb_responder: RTL
======================

UCIE_SB_RESPONDER -- requirements
Module: ucie_sb_responder

Interface
REQ-001 Parameters (name, default, meaning): CODE_W, 4, request/response message-code width; DLY_W, 8, response-delay field width.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: en  input  1  block enable; low forces idle.
REQ-005 Port: req_valid  input  1  initiator request strobe.
REQ-006 Port: req_code  input  CODE_W  request message code.
REQ-007 Port: rsp_delay  input  DLY_W  programmed cycles to wait before responding.
REQ-008 Port: rsp_ready  input  1  initiator accepts response.
REQ-009 Port: rsp_valid  output  1  response present, registered.
REQ-010 Port: rsp_code  output  CODE_W  response code, registered.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: err_unsup  output  1  one-cycle pulse, unsupported request code.
REQ-013 Port: err_overrun  output  1  one-cycle pulse, request arrived while busy.
REQ-014 Port: err_hold_tmo  output  1  one-cycle pulse, response not accepted in time.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 IDLE: request accepted when en=1 and req_valid=1 and req_code MSB=0; next state WAIT, code latched, counter loaded with min(rsp_delay, 88).
REQ-017 IDLE with req_valid=1 and req_code MSB=1 SHALL pulse err_unsup next cycle and stay IDLE.
REQ-018 WAIT: counter==0 -> RESP, else counter decrements by 1.
REQ-019 rsp_valid SHALL first be high clk cycles min(rsp_delay,88)+1 after the accepting edge (delay 0 -> high the cycle after acceptance); the clamp at 88 keeps the response inside the initiator's 90-cycle handshake timeout.
REQ-020 rsp_code SHALL equal latched req_code with MSB set (request 0x3 -> response 0xB), stable while rsp_valid=1.
REQ-021 RESP: rsp_valid and rsp_code held until rsp_ready=1; on that edge -> IDLE, rsp_valid low next cycle.
REQ-022 RESP hold counter SHALL count cycles in RESP; reaching 150 without rsp_ready -> IDLE, rsp_valid low, err_hold_tmo pulses one cycle.
REQ-023 rsp_ready and hold counter==150 on the same edge: handshake wins, no err_hold_tmo.
REQ-024 req_valid=1 in WAIT or RESP SHALL be ignored and pulse err_overrun; the in-flight response is unaffected.
REQ-025 A request is never accepted on the same edge as an rsp_ready handshake; one IDLE cycle minimum between responses.
REQ-026 en=0 in any state SHALL force IDLE next edge, clear counters, drive rsp_valid=0, no error pulse.
REQ-027 rsp_delay is sampled only at acceptance; later changes do not affect the in-flight request.
REQ-028 All error pulses are exactly one cycle and mutually independent.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, counters 0, rsp_valid=0, rsp_code=0, busy=0, all error outputs 0, regardless of en or state (including mid-WAIT/RESP).
REQ-030 First request is accepted on the first edge with rst=0, en=1, req_valid=1.

Structure
REQ-031 Shared package ucie_sb_pkg SHALL hold the state encoding, MAX_RSP_DELAY=88, RSP_HOLD_TIMEOUT=150, RSP_CODE_FLAG (MSB set).
REQ-032 The load/decrement/zero-detect counter SHALL be one sub-module sb_down_counter, instantiated for the delay count; the hold count is a local up-counter.

Verification
REQ-033 rst released, en=1, req_code=0x2, rsp_delay=5, rsp_ready=1 held -> rsp_valid high exactly 6 cycles after acceptance for 1 cycle, rsp_code=0xA.
REQ-034 rsp_delay=200, req_code=0x1 -> rsp_valid high 89 cycles after acceptance, rsp_code=0x9.
REQ-035 req_code=0x9 in IDLE -> err_unsup one pulse, busy stays 0, no rsp_valid.
REQ-036 rsp_ready held 0 -> rsp_valid high 150 cycles, then low with one err_hold_tmo pulse; variant with rsp_ready=1 on cycle 150 -> clean handshake, no error.
REQ-037 Second req_valid during WAIT -> err_overrun pulse, first response delivered unchanged; en dropped mid-RESP -> idle next cycle, no error.
REQ-038 rst=1 asserted mid-WAIT -> all outputs 0 next cycle; new request after release honored normally.

Source files
------------

// File: rtl/ucie_sb_pkg.sv
// Shared types and constants for the UCIe sideband responder.
// Holds the FSM encoding, the delay/hold limits and the response-code flag.
package ucie_sb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } sb_state_e;

   // Clamp keeps the response inside the initiator's 90-cycle handshake timeout.
   localparam int unsigned MAX_RSP_DELAY    = 88;
   localparam int unsigned RSP_HOLD_TIMEOUT = 150;
   localparam int unsigned HOLD_W           = $clog2(RSP_HOLD_TIMEOUT + 1);

   // Flag for the default 4-bit code; rsp_code_flag() gives it for any width.
   localparam logic [3:0]  RSP_CODE_FLAG    = 4'b1000;

   function automatic logic [31:0] rsp_code_flag(input int unsigned code_w);
      return 32'd1 << (code_w - 1);
   endfunction

endpackage

// File: rtl/sb_down_counter.sv
// Loadable down-counter with zero detect; holds at zero rather than wrapping.
module sb_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ucie_sb_responder.sv
// Sideband request responder: accepts a request, waits a programmed delay,
// then presents a flagged response until accepted or the hold timeout expires.
module ucie_sb_responder
   import ucie_sb_pkg::*;
#(
   parameter int unsigned CODE_W = 4,
   parameter int unsigned DLY_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              req_valid,
   input  logic [CODE_W-1:0] req_code,
   input  logic [DLY_W-1:0]  rsp_delay,
   input  logic              rsp_ready,
   output logic              rsp_valid,
   output logic [CODE_W-1:0] rsp_code,
   output logic              busy,
   output logic              err_unsup,
   output logic              err_overrun,
   output logic              err_hold_tmo
);

   localparam logic [CODE_W-1:0] CodeFlag = CODE_W'(rsp_code_flag(CODE_W));

   sb_state_e         state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              rsp_valid_q;
   logic              unsup_q, unsup_d;
   logic              overrun_q, overrun_d;
   logic              hold_tmo_q, hold_tmo_d;

   logic [DLY_W-1:0]  dly_load_val;
   logic              dly_load, dly_dec, dly_clr, dly_zero;

   assign dly_load_val = (32'(rsp_delay) > MAX_RSP_DELAY) ? DLY_W'(MAX_RSP_DELAY) : rsp_delay;

   sb_down_counter #(
      .W (DLY_W)
   ) u_dly_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (dly_clr),
      .load     (dly_load),
      .load_val (dly_load_val),
      .dec      (dly_dec),
      .zero     (dly_zero)
   );

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      hold_d     = hold_q;
      dly_load   = 1'b0;
      dly_dec    = 1'b0;
      dly_clr    = 1'b0;
      unsup_d    = 1'b0;
      overrun_d  = 1'b0;
      hold_tmo_d = 1'b0;

      if (!en) begin
         state_d = StIdle;
         hold_d  = '0;
         dly_clr = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  if (req_code[CODE_W-1]) begin
                     unsup_d = 1'b1;
                  end else begin
                     state_d  = StWait;
                     code_d   = req_code | CodeFlag;
                     dly_load = 1'b1;
                  end
               end
            end
            StWait: begin
               overrun_d = req_valid;
               if (dly_zero) begin
                  state_d = StResp;
                  hold_d  = HOLD_W'(1);
               end else begin
                  dly_dec = 1'b1;
               end
            end
            StResp: begin
               overrun_d = req_valid;
               // Handshake takes priority over an expiring hold timer.
               if (rsp_ready) begin
                  state_d = StIdle;
                  hold_d  = '0;
               end else if (hold_q == HOLD_W'(RSP_HOLD_TIMEOUT)) begin
                  state_d    = StIdle;
                  hold_d     = '0;
                  hold_tmo_d = 1'b1;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         code_q      <= '0;
         hold_q      <= '0;
         rsp_valid_q <= 1'b0;
         unsup_q     <= 1'b0;
         overrun_q   <= 1'b0;
         hold_tmo_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         hold_q      <= hold_d;
         rsp_valid_q <= (state_d == StResp);
         unsup_q     <= unsup_d;
         overrun_q   <= overrun_d;
         hold_tmo_q  <= hold_tmo_d;
      end
   end

   assign rsp_valid    = rsp_valid_q;
   assign rsp_code     = code_q;
   assign busy         = (state_q != StIdle);
   assign err_unsup    = unsup_q;
   assign err_overrun  = overrun_q;
   assign err_hold_tmo = hold_tmo_q;

endmodule
